keyexpansion_gen: RTL

KEYEXPANSION_GEN -- requirements
Module: keyexpansion_gen

---
 rtl/keyexpansion_gen.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/keyexpansion_gen.sv
// AES key expansion engine (FIPS-197) for 128/192/256-bit keys.
// One word per cycle for plain words, two cycles for SubWord words, all
// SubWord steps share four byte-lane S-boxes.
// Optional build macro: KEYEXPANSION_ZEROIZE_EN -- when defined, reset and
// every rejected start wipe the round-key storage to zero.

// Single-byte AES S-box: multiplicative inverse in GF(2^8) followed by the
// affine transform, computed rather than tabulated.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) begin
        p = p ^ aa;
      end else begin
        p = p;
      end
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 for non-zero a, and maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int n = 0; n < 8; n++) begin
      if (n != 0) begin
        r = gf_mul(r, s);
      end else begin
        r = r;
      end
      s = gf_mul(s, s);
    end
    return r;
  endfunction

  logic [7:0] inv_s;

  // Inverse then affine transform b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
  always_comb begin
    inv_s    = gf_inv(in_byte);
    out_byte = inv_s
             ^ {inv_s[6:0], inv_s[7]}
             ^ {inv_s[5:0], inv_s[7:6]}
             ^ {inv_s[4:0], inv_s[7:5]}
             ^ {inv_s[3:0], inv_s[7:4]}
             ^ 8'h63;
  end

endmodule

module keyexpansion_gen #(
  parameter int KEY_LEN_MAX = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] key,
  input  logic [1:0]   key_len,
  input  logic         start,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk,
  output logic [3:0]   num_rounds,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int NW = (KEY_LEN_MAX / 32 + 7) * 4;

  typedef enum logic [1:0] {IDLE, EXPAND, SUB, DONE} state_t;

  state_t      state_r, state_next;
  logic [31:0] w_r [NW];
  logic [5:0]  i_r;
  logic [2:0]  j_r;          // i mod Nk, tracked incrementally
  logic [3:0]  nk_r;
  logic [7:0]  rcon_r;
  logic [31:0] sub_in_r;

  logic        accept_s, reject_s, wr_en_s, step_s, sub_load_s, rcon_step_s;
  logic [31:0] wr_data_s, sub_in_next_s, temp_s, prev_s, sub_out_s, sub_word_s;
  logic        len_ok_s, rot_s, sub_need_s, last_s;
  logic [3:0]  nk_new_s, nr_new_s;
  logic [5:0]  rk_base_s;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  aes_sbox u_sbox0 (.in_byte(sub_in_r[31:24]), .out_byte(sub_out_s[31:24]));
  aes_sbox u_sbox1 (.in_byte(sub_in_r[23:16]), .out_byte(sub_out_s[23:16]));
  aes_sbox u_sbox2 (.in_byte(sub_in_r[15:8]),  .out_byte(sub_out_s[15:8]));
  aes_sbox u_sbox3 (.in_byte(sub_in_r[7:0]),   .out_byte(sub_out_s[7:0]));

  // Decode requested key length into Nk / rounds and check it is buildable
  always_comb begin
    nk_new_s = 4'd8;
    nr_new_s = 4'd14;
    len_ok_s = 1'b0;
    case (key_len)
      2'b00: begin nk_new_s = 4'd4; nr_new_s = 4'd10; len_ok_s = 1'b1; end
      2'b01: begin nk_new_s = 4'd6; nr_new_s = 4'd12; len_ok_s = (KEY_LEN_MAX >= 192); end
      2'b10: begin nk_new_s = 4'd8; nr_new_s = 4'd14; len_ok_s = (KEY_LEN_MAX >= 256); end
      default: begin nk_new_s = 4'd8; nr_new_s = 4'd14; len_ok_s = 1'b0; end
    endcase
  end

  // Next-state and datapath strobes for the expansion sequencer
  always_comb begin
    state_next    = state_r;
    accept_s      = 1'b0;
    reject_s      = 1'b0;
    wr_en_s       = 1'b0;
    wr_data_s     = 32'h0;
    step_s        = 1'b0;
    sub_load_s    = 1'b0;
    sub_in_next_s = 32'h0;
    rcon_step_s   = 1'b0;
    temp_s        = w_r[i_r - 6'd1];
    prev_s        = w_r[i_r - {2'b00, nk_r}];
    rot_s         = (j_r == 3'd0);
    sub_need_s    = rot_s || ((nk_r == 4'd8) && (j_r == 3'd4));
    sub_word_s    = rot_s ? (sub_out_s ^ {rcon_r, 24'h0}) : sub_out_s;
    last_s        = (i_r == {num_rounds, 2'b11});
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          if (len_ok_s) begin
            accept_s   = 1'b1;
            state_next = EXPAND;
          end else begin
            reject_s   = 1'b1;
          end
        end else begin
          state_next = state_r;
        end
      end
      EXPAND: begin
        if (sub_need_s) begin
          sub_load_s    = 1'b1;
          sub_in_next_s = rot_s ? {temp_s[23:0], temp_s[31:24]} : temp_s;
          state_next    = SUB;
        end else begin
          wr_en_s    = 1'b1;
          wr_data_s  = prev_s ^ temp_s;
          step_s     = 1'b1;
          state_next = last_s ? DONE : EXPAND;
        end
      end
      SUB: begin
        wr_en_s     = 1'b1;
        wr_data_s   = prev_s ^ sub_word_s;
        step_s      = 1'b1;
        rcon_step_s = rot_s;
        state_next  = last_s ? DONE : EXPAND;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control registers: state, word index, Rcon, status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      num_rounds <= 4'd0;
      i_r        <= 6'd0;
      j_r        <= 3'd0;
      nk_r       <= 4'd0;
      rcon_r     <= 8'h01;
      sub_in_r   <= 32'h0;
    end else begin
      state_r <= state_next;
      err     <= reject_s;
      if (accept_s) begin
        busy       <= 1'b1;
        done       <= 1'b0;
        i_r        <= {2'b00, nk_new_s};
        j_r        <= 3'd0;
        nk_r       <= nk_new_s;
        num_rounds <= nr_new_s;
        rcon_r     <= 8'h01;
      end else if (step_s) begin
        i_r <= i_r + 6'd1;
        j_r <= (j_r == (nk_r[2:0] - 3'd1)) ? 3'd0 : (j_r + 3'd1);
        if (last_s) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
      if (rcon_step_s) begin
        rcon_r <= xtime(rcon_r);
      end
      if (sub_load_s) begin
        sub_in_r <= sub_in_next_s;
      end
    end
  end

  // Word storage: key load on accept, one expanded word per write strobe
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef KEYEXPANSION_ZEROIZE_EN
      for (int n = 0; n < NW; n++) begin
        w_r[n] <= 32'h0;
      end
`endif
    end else if (accept_s) begin
      for (int n = 0; n < 8; n++) begin
        if (n < int'(nk_new_s)) begin
          w_r[n] <= key[255 - 32*n -: 32];
        end
      end
    end else if (wr_en_s) begin
      w_r[i_r] <= wr_data_s;
    end
`ifdef KEYEXPANSION_ZEROIZE_EN
    else if (reject_s) begin
      for (int n = 0; n < NW; n++) begin
        w_r[n] <= 32'h0;
      end
    end
`endif
  end

  // Round-key read port; indices past the last round read as zero
  always_comb begin
    rk_base_s = 6'd0;
    rk        = 128'h0;
    if (rk_idx <= num_rounds) begin
      rk_base_s = {rk_idx, 2'b00};
      rk = {w_r[rk_base_s], w_r[rk_base_s + 6'd1],
            w_r[rk_base_s + 6'd2], w_r[rk_base_s + 6'd3]};
    end else begin
      rk = 128'h0;
    end
  end

endmodule
